nibble_lane_collector: RTL

//   Sink end of the four-lane nibble interface. An instance array drives the lanes a/b/c/d,
//   and any lane may be left unconnected there.

---
 rtl/nibble_lane_collector.sv | 109 ++++++++++
 1 files changed

// File: rtl/nibble_lane_collector.sv
// Four-lane nibble sink: samples lanes on a strobe, packs them into a word,
// and queues words in a small FIFO drained over a valid/ready stream.
module nibble_lane_collector #(
  parameter int unsigned LANE_W = 4,
  parameter int unsigned DEPTH = 4,
  parameter logic [LANE_W-1:0] DEFAULT_NIB = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       sample_i,
  input  logic [3:0]                 lane_en_i,
  input  logic [LANE_W-1:0]          a_i,
  input  logic [LANE_W-1:0]          b_i,
  input  logic [LANE_W-1:0]          c_i,
  input  logic [LANE_W-1:0]          d_i,
  output logic [4*LANE_W-1:0]        word_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = 4 * LANE_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WW-1:0] mem [DEPTH];

  logic [WW-1:0] word_q, word_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;

  logic [WW-1:0] cap;
  logic          full, push, pop, we;
  logic          head_new;

  always_comb begin
    cap = {
      lane_en_i[3] ? d_i : DEFAULT_NIB,
      lane_en_i[2] ? c_i : DEFAULT_NIB,
      lane_en_i[1] ? b_i : DEFAULT_NIB,
      lane_en_i[0] ? a_i : DEFAULT_NIB
    };
    full = (count_q == FULL);
    pop  = valid_q && ready_i;
    push = sample_i && (!full || pop);
    we   = push && !clear_i;

    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The pushed word becomes the head when nothing older survives this edge.
    head_new = push && (count_q == CW'(pop));
    word_d   = word_q;
    if (count_d != '0) begin
      word_d = head_new ? cap : mem[rptr_d];
    end
    valid_d = (count_d != '0);
    ovf_d   = ovf_q | (sample_i && full && !pop);

    if (clear_i) begin
      word_d  = word_q;
      valid_d = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
      wptr_d  = '0;
      rptr_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  assign word_o     = word_q;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule
